// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for load-use, taken-branch and memory-wait hazards.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   id_rs1/id_rs2              source registers of the instruction in ID
//   id_uses_rs1/id_uses_rs2    ID instruction reads rs1/rs2
//   ex_rd                      destination register of the instruction in EXE
//   ex_mem_read/ex_reg_write   EXE instruction is a load / writes the register file
//   branch_taken               branch/jump resolved taken in EXE
//   mem_req/mem_ready          MEM-stage data access and its completion
//   stall_*/flush_*            combinational pipeline-register controls
//   lu_active                  FSM is inserting extra load-use bubbles
//   wait_timeout               sticky: a memory wait reached MAX_WAIT cycles
//   stall_cycles/flush_count   saturating performance counters
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MAX_WAIT     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              stall_id_exe,
    output logic              stall_exe_mem,
    output logic              flush_if_id,
    output logic              flush_id_exe,
    output logic              lu_active,
    output logic              wait_timeout,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);
    typedef enum logic {RUN, LU_STALL} state_t;

    state_t      r_state;
    logic [1:0]  r_lu_cnt;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    logic w_mw;
    logic w_lu;
    logic w_bt;
    logic w_bub;

    assign w_mw  = mem_req & ~mem_ready;
    assign w_lu  = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    // A branch under a memory wait is deferred: the EXE instruction is still held.
    assign w_bt  = ~w_mw & branch_taken;
    assign w_bub = ~w_mw & ~branch_taken & ((r_state == LU_STALL) | w_lu);

    assign stall_pc      = ~reset & (w_mw | w_bub);
    assign stall_if_id   = ~reset & (w_mw | w_bub);
    assign stall_id_exe  = ~reset & w_mw;
    assign stall_exe_mem = ~reset & w_mw;
    assign flush_if_id   = ~reset & w_bt;
    assign flush_id_exe  = ~reset & (w_bt | w_bub);

    assign lu_active    = (r_state == LU_STALL);
    assign wait_timeout = r_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= RUN;
            r_lu_cnt       <= '0;
            r_wait_cnt     <= '0;
            r_timeout      <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_mw) begin
                if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
                if (r_wait_cnt == 8'(MAX_WAIT - 1)) r_timeout <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
                if (w_bt) begin
                    r_state  <= RUN;
                    r_lu_cnt <= '0;
                end else if (r_state == LU_STALL) begin
                    if (r_lu_cnt == 2'(LOAD_BUBBLES - 1)) begin
                        r_state  <= RUN;
                        r_lu_cnt <= '0;
                    end else begin
                        r_lu_cnt <= r_lu_cnt + 2'd1;
                    end
                end else if (w_lu && LOAD_BUBBLES > 1) begin
                    r_state  <= LU_STALL;
                    r_lu_cnt <= 2'd1;
                end
            end
            if (w_bt && r_flush_count != '1) r_flush_count <= r_flush_count + 32'd1;
            if ((w_mw | w_bub) && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end
endmodule
